// File: rtl/alu_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_sweep_ctrl
// Purpose  : Self-test initiator for the 8-bit ALU. An accepted start latches
//            two operands and steps ALU_sel through every opcode. Each opcode
//            is held for SETTLE_CYCLES cycles and then captured for one cycle.
//            Each result is written into a result buffer and folded into a
//            rotate-xor signature. The buffer is read through a registered
//            port.
// Ports    : clk, rst_n (async, active-low)
//            start/abort          - sweep request / cancel
//            op_a, op_b           - operands, latched on accepted start
//            A, B, ALU_sel        - stimulus to the ALU
//            ALU_result           - combinational ALU output
//            busy, done           - sweep running / sweep complete (level)
//            signature            - running result signature
//            rd_addr, rd_data     - buffer read port, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module alu_sweep_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [SEL_W-1:0] ALU_sel,
  input  logic [WIDTH-1:0] ALU_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  input  logic [SEL_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int               c_DEPTH     = 1 << SEL_W;
  localparam logic [3:0]       c_SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] c_LAST_SEL  = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // With no settle time, each opcode goes straight to its capture cycle.
  localparam state_t c_OP_ENTRY = (c_SETTLE_LD != 4'd0) ? S_SETTLE : S_CAPTURE;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_capture;
  logic             w_last;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] r_rd;
  logic [WIDTH-1:0] r_buf [c_DEPTH];

  assign w_last = (r_sel == c_LAST_SEL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and datapath strobes. Abort takes priority over the
  // capture write, so a cancelled sweep never writes the current opcode.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = c_OP_ENTRY;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_capture = 1'b1;
          w_next    = w_last ? S_DONE : c_OP_ENTRY;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Settle counter, operands, opcode, signature and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_a   <= '0;
      r_b   <= '0;
      r_sel <= '0;
      r_sig <= '0;
      r_rd  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= c_SETTLE_LD;
        r_a   <= op_a;
        r_b   <= op_b;
        r_sel <= '0;
        r_sig <= '0;
      end else if (w_capture) begin
        r_cnt <= c_SETTLE_LD;
        r_sig <= {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ ALU_result;
        // ALU_sel parks on the last opcode; it only returns to 0 on start.
        if (!w_last) begin
          r_sel <= r_sel + 1'b1;
        end
      end else if ((r_state == S_SETTLE) && !abort) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read happens before this edge's buffer write, so a same-cycle
      // read of the entry being captured returns the old contents.
      r_rd <= r_buf[rd_addr];
    end
  end

  // Result buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_capture) begin
      r_buf[r_sel] <= ALU_result;
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign ALU_sel   = r_sel;
  assign signature = r_sig;
  assign rd_data   = r_rd;
  assign busy      = (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sweep_ctrl
// Purpose  : Self-checking bench for alu_sweep_ctrl. Two instances share all
//            control inputs. Instance 0 uses SETTLE_CYCLES=1 and a full
//            16-op ALU model. Instance 1 uses SETTLE_CYCLES=0 and can switch
//            to a constant-0x01 stub ALU. A time-based reference model
//            predicts every output after every clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stub  = 1'b0;
  logic [7:0] op_a  = 8'h00;
  logic [7:0] op_b  = 8'h00;
  logic [3:0] rd_addr = 4'h0;

  logic [7:0] a0, b0, sig0, rd0, res0, a1, b1, sig1, rd1, res1;
  logic [3:0] sel0, sel1;
  logic       busy0, done0, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
    case (s)
      4'd0:    return 8'(a + b);
      4'd1:    return 8'(a - b);
      4'd2:    return 8'(a * b);
      4'd3:    return (b == 8'd0) ? 8'h00 : 8'(a / b);
      4'd4:    return {a[6:0], 1'b0};
      4'd5:    return {1'b0, a[7:1]};
      4'd6:    return {a[6:0], a[7]};
      4'd7:    return {a[0], a[7:1]};
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return ~(a | b);
      4'd12:   return ~(a & b);
      4'd13:   return ~(a ^ b);
      4'd14:   return (a > b) ? 8'h01 : 8'h00;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  assign res0 = alu_ref(a0, b0, sel0);
  assign res1 = stub ? 8'h01 : alu_ref(a1, b1, sel1);

  alu_sweep_ctrl #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .A(a0), .B(b0), .ALU_sel(sel0),
    .ALU_result(res0), .busy(busy0), .done(done0), .signature(sig0),
    .rd_addr(rd_addr), .rd_data(rd0)
  );

  alu_sweep_ctrl #(.WIDTH(8), .SEL_W(4), .SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .A(a1), .B(b1), .ALU_sel(sel1),
    .ALU_result(res1), .busy(busy1), .done(done1), .signature(sig1),
    .rd_addr(rd_addr), .rd_data(rd1)
  );

  // Reference model state, one slot per instance
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic [7:0] m_sig [2];
  logic [7:0] m_rd [2];
  logic [3:0] m_sel [2];
  logic       m_busy [2];
  logic       m_done [2];
  int         m_t [2];
  logic [7:0] m_buf [2][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_a[id] = 8'h00; m_b[id] = 8'h00; m_sig[id] = 8'h00; m_rd[id] = 8'h00;
      m_sel[id] = 4'h0; m_busy[id] = 1'b0; m_done[id] = 1'b0; m_t[id] = 0;
      for (int i = 0; i < 16; i++) m_buf[id][i] = 8'h00;
    end
  endtask

  // Opcode k is captured (k+1)*(s+1) cycles after the accepted start.
  task automatic model_step(input int id, input int s);
    logic [7:0] r;
    int k;
    m_rd[id] = m_buf[id][rd_addr];
    if (!m_busy[id]) begin
      if (start) begin
        m_a[id] = op_a; m_b[id] = op_b; m_sel[id] = 4'h0; m_sig[id] = 8'h00;
        m_done[id] = 1'b0; m_busy[id] = 1'b1; m_t[id] = 0;
      end
    end else if (abort) begin
      m_busy[id] = 1'b0;
      m_done[id] = 1'b0;
    end else begin
      m_t[id]++;
      if (m_t[id] % (s + 1) == 0) begin
        k = m_t[id] / (s + 1) - 1;
        r = (id == 1 && stub) ? 8'h01 : alu_ref(m_a[id], m_b[id], 4'(k));
        m_buf[id][k] = r;
        m_sig[id] = {m_sig[id][6:0], m_sig[id][7]} ^ r;
        if (k == 15) begin
          m_busy[id] = 1'b0;
          m_done[id] = 1'b1;
        end else begin
          m_sel[id] = 4'(k + 1);
        end
      end
    end
  endtask

  task automatic check_dut(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sel, input logic bs, input logic dn,
                           input logic [7:0] sg, input logic [7:0] rd);
    check($sformatf("d%0d_A", id),         32'(a),   32'(m_a[id]));
    check($sformatf("d%0d_B", id),         32'(b),   32'(m_b[id]));
    check($sformatf("d%0d_ALU_sel", id),   32'(sel), 32'(m_sel[id]));
    check($sformatf("d%0d_busy", id),      32'(bs),  32'(m_busy[id]));
    check($sformatf("d%0d_done", id),      32'(dn),  32'(m_done[id]));
    check($sformatf("d%0d_signature", id), 32'(sg),  32'(m_sig[id]));
    check($sformatf("d%0d_rd_data", id),   32'(rd),  32'(m_rd[id]));
  endtask

  task automatic check_all();
    check_dut(0, a0, b0, sel0, busy0, done0, sig0, rd0);
    check_dut(1, a1, b1, sel1, busy1, done1, sig1, rd1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, 1);
      model_step(1, 0);
    end
    #1;
    check_all();
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [7:0] ra, rb;
    model_reset();

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Directed sweep: operand latch, result buffer, timing
    pulse_start(8'hD5, 8'h4E);
    check("A_latched", 32'(a0), 32'hD5);
    check("B_latched", 32'(b0), 32'h4E);
    check("busy_rise", 32'(busy0), 32'd1);
    cnt = 0;
    do begin tick(); cnt++; end while (!done0 && cnt < 40);
    check("done0_latency", 32'(cnt), 32'd32);
    tick();
    check("sel_hold15", 32'(sel0), 32'd15);
    rd_addr = 4'd0;  tick(); check("buf0_add", 32'(rd0), 32'h23);
    rd_addr = 4'd8;  tick(); check("buf8_and", 32'(rd0), 32'h44);
    rd_addr = 4'd10; tick(); check("buf10_xor", 32'(rd0), 32'h9B);

    // Stub ALU on the zero-settle instance
    stub = 1'b1;
    pulse_start(8'h12, 8'h34);
    repeat (8) tick();
    check("sig1_after8", 32'(sig1), 32'hFF);
    cnt = 8;
    while (!done1 && cnt < 40) begin tick(); cnt++; end
    check("done1_latency", 32'(cnt), 32'd16);
    check("sig1_final", 32'(sig1), 32'h00);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); tick();
      check($sformatf("stub_buf%0d", i), 32'(rd1), 32'h01);
    end
    stub = 1'b0;
    repeat (20) tick();

    // Asynchronous reset in the settle phase of opcode 9
    pulse_start(8'($urandom), 8'($urandom));
    cnt = 0;
    while (sel0 != 4'd9 && cnt < 40) begin tick(); cnt++; end
    check("wait_sel9", 32'(sel0), 32'd9);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_async_busy", 32'(busy0), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); tick();
      check($sformatf("rst_buf%0d", i), 32'(rd0), 32'h00);
    end

    // Abort at opcode 5, with an ignored start re-pulse mid-sweep
    ra = 8'($urandom); rb = 8'($urandom);
    pulse_start(ra, rb);
    repeat (3) tick();
    pulse_start(8'($urandom), 8'($urandom));
    check("restart_ignored_A", 32'(a0), 32'(ra));
    cnt = 0;
    while (sel0 != 4'd5 && cnt < 40) begin tick(); cnt++; end
    check("wait_sel5", 32'(sel0), 32'd5);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); tick();
      check($sformatf("abort_buf%0d", i), 32'(rd0),
            (i < 5) ? 32'(alu_ref(ra, rb, 4'(i))) : 32'h0);
    end

    // New sweep after abort completes normally
    pulse_start(8'($urandom), 8'($urandom));
    cnt = 0;
    while (!done0 && cnt < 40) begin tick(); cnt++; end
    check("post_abort_done", 32'(done0), 32'd1);

    // Start from DONE with new operands
    pulse_start(8'h00, 8'hFF);
    check("restart_done_clr", 32'(done0), 32'd0);
    check("restart_sig_clr", 32'(sig0), 32'd0);
    cnt = 0;
    while (!done0 && cnt < 40) begin tick(); cnt++; end
    rd_addr = 4'd0; tick();
    check("restart_buf0", 32'(rd0), 32'hFF);

    // Random traffic
    repeat (800) begin
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      stub    = 1'($urandom_range(0, 1));
      op_a    = 8'($urandom);
      op_b    = 8'($urandom);
      rd_addr = 4'($urandom);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
